// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment display path: segment patterns, anode encoding, widths.
package seg_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned SEL_W      = 2;
  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned SEG_W      = 7;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_A     = 7'b0001000;
  localparam logic [SEG_W-1:0] SEG_B     = 7'b0000011;
  localparam logic [SEG_W-1:0] SEG_C     = 7'b1000110;
  localparam logic [SEG_W-1:0] SEG_D     = 7'b0100001;
  localparam logic [SEG_W-1:0] SEG_E     = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_F     = 7'b0001110;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  localparam logic [NUM_DIGITS-1:0] AN_OFF = 4'b1111;

  typedef logic [NUM_DIGITS-1:0][DIGIT_W-1:0] digits_t;

  // Active-low one-hot anode for a digit index
  function automatic logic [NUM_DIGITS-1:0] an_onehot(input logic [SEL_W-1:0] s);
    return ~(NUM_DIGITS'(1) << s);
  endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational 4-bit value to active-low 7-segment decode; 10-15 render as hex A,b,C,d,E,F.
module bcd_to_7seg
  import seg_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  output logic [SEG_W-1:0]   seg_c
);

  always_comb begin
    seg_c = SEG_BLANK;
    case (digit)
      4'h0: seg_c = SEG_0;
      4'h1: seg_c = SEG_1;
      4'h2: seg_c = SEG_2;
      4'h3: seg_c = SEG_3;
      4'h4: seg_c = SEG_4;
      4'h5: seg_c = SEG_5;
      4'h6: seg_c = SEG_6;
      4'h7: seg_c = SEG_7;
      4'h8: seg_c = SEG_8;
      4'h9: seg_c = SEG_9;
      4'hA: seg_c = SEG_A;
      4'hB: seg_c = SEG_B;
      4'hC: seg_c = SEG_C;
      4'hD: seg_c = SEG_D;
      4'hE: seg_c = SEG_E;
      4'hF: seg_c = SEG_F;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a 4-digit common-anode 7-segment display with
// per-frame input snapshot, inter-digit blanking and optional leading-zero suppression.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned CLK_DIV      = 100000,
  parameter int unsigned BLANK_CYCLES = 1000,
  parameter int unsigned CNT_W        = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  lzb,
  input  logic [DIGIT_W-1:0]    i0,
  input  logic [DIGIT_W-1:0]    i1,
  input  logic [DIGIT_W-1:0]    i2,
  input  logic [DIGIT_W-1:0]    i3,
  output logic [SEL_W-1:0]      sel,
  output logic [NUM_DIGITS-1:0] an,
  output logic [SEG_W-1:0]      seg,
  output logic                  digit_tick
);

  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);
  localparam logic [SEL_W-1:0] SEL_LAST  = SEL_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cnt_nxt;
  logic [SEL_W-1:0]      sel_nxt;
  digits_t               snap;
  digits_t               snap_nxt;
  logic                  tick_nxt;
  logic [NUM_DIGITS-1:0] blank;
  logic                  lit;
  logic [SEG_W-1:0]      dec_seg;
  logic [NUM_DIGITS-1:0] an_nxt;
  logic [SEG_W-1:0]      seg_nxt;

  // Prescaler, digit rotation and frame snapshot on the 3->0 wrap
  always_comb begin
    cnt_nxt  = cnt;
    sel_nxt  = sel;
    snap_nxt = snap;
    tick_nxt = 1'b0;
    if (en) begin
      if (cnt == CNT_MAX) begin
        cnt_nxt  = '0;
        sel_nxt  = sel + SEL_W'(1);
        tick_nxt = 1'b1;
        if (sel == SEL_LAST) begin
          snap_nxt = {i3, i2, i1, i0};
        end
      end else begin
        cnt_nxt = cnt + CNT_W'(1);
      end
    end
  end

  // Leading-zero chain from the most significant digit; digit 0 always shows
  always_comb begin
    blank    = '0;
    blank[3] = lzb && (snap_nxt[3] == DIGIT_W'(0));
    blank[2] = blank[3] && (snap_nxt[2] == DIGIT_W'(0));
    blank[1] = blank[2] && (snap_nxt[1] == DIGIT_W'(0));
  end

  bcd_to_7seg u_dec (
    .digit (snap_nxt[sel_nxt]),
    .seg_c (dec_seg)
  );

  // Outputs are computed from next-state values so they line up with the registered sel/cnt
  always_comb begin
    lit     = en && (cnt_nxt >= BLANK_END) && !blank[sel_nxt];
    an_nxt  = AN_OFF;
    seg_nxt = SEG_BLANK;
    if (lit) begin
      an_nxt  = an_onehot(sel_nxt);
      seg_nxt = dec_seg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      sel        <= '0;
      snap       <= '0;
      an         <= AN_OFF;
      seg        <= SEG_BLANK;
      digit_tick <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      sel        <= sel_nxt;
      snap       <= snap_nxt;
      an         <= an_nxt;
      seg        <= seg_nxt;
      digit_tick <= tick_nxt;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with CLK_DIV=4, BLANK_CYCLES=1; each scenario checks
// {sel, an, seg, digit_tick} every clock against hand-derived slot expectations.
module tb_seg_scan_ctrl;

  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned BLANK   = 1;
  localparam int unsigned CNT_W   = 3;

  logic       clk;
  logic       rst;
  logic       en;
  logic       lzb;
  logic [3:0] i0, i1, i2, i3;
  logic [1:0] sel;
  logic [3:0] an;
  logic [6:0] seg;
  logic       digit_tick;

  int n_checks = 0;
  int n_fail   = 0;

  seg_scan_ctrl #(
    .CLK_DIV      (CLK_DIV),
    .BLANK_CYCLES (BLANK),
    .CNT_W        (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .lzb        (lzb),
    .i0         (i0),
    .i1         (i1),
    .i2         (i2),
    .i3         (i3),
    .sel        (sel),
    .an         (an),
    .seg        (seg),
    .digit_tick (digit_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-written decode table
  function automatic logic [6:0] dec_ref(input logic [3:0] d);
    case (d)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  function automatic logic [3:0] exp_an(input int s, input int c, input bit lit);
    logic [3:0] one;
    one = 4'b0001;
    if (!lit || c < int'(BLANK)) return 4'b1111;
    return ~(one << s);
  endfunction

  function automatic logic [6:0] exp_seg(input int c, input bit lit, input logic [3:0] d);
    if (!lit || c < int'(BLANK)) return 7'b1111111;
    return dec_ref(d);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [13:0] got, want;
    rst = 1'b1; en = 1'b0; lzb = 1'b0;
    i0 = 4'h0; i1 = 4'h0; i2 = 4'h0; i3 = 4'h0;
    step();
    step();
    want = {2'd0, 4'b1111, 7'b1111111, 1'b0};
    got  = {sel, an, seg, digit_tick};
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL reset_held: got %b want %b", got, want);
    end
    rst = 1'b0;
    step();
    got = {sel, an, seg, digit_tick};
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL reset_release_en0: got %b want %b", got, want);
    end
  endtask

  // Frame 1 shows reset snapshot (zeros), frame 2 shows 0,1,2,3
  task automatic test_basic_scan();
    logic [13:0] got, want;
    int s, c;
    logic [3:0] d;
    i0 = 4'h0; i1 = 4'h1; i2 = 4'h2; i3 = 4'h3;
    en = 1'b1;
    for (int e = 1; e < 32; e++) begin
      step();
      s = (e / 4) % 4;
      c = e % 4;
      d = (e < 16) ? 4'h0 : 4'(s);
      want = {2'(s), exp_an(s, c, 1'b1), exp_seg(c, 1'b1, d), (c == 0)};
      got  = {sel, an, seg, digit_tick};
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL basic_scan e=%0d: got sel=%0d an=%b seg=%b tick=%b want sel=%0d an=%b seg=%b tick=%b",
                 e, got[13:12], got[11:8], got[7:1], got[0], want[13:12], want[11:8], want[7:1], want[0]);
      end
    end
  endtask

  task automatic test_snapshot_isolation();
    logic [13:0] got, want;
    logic [3:0] fa [4];
    logic [3:0] fb [4];
    int s, c;
    fa = '{4'h0, 4'h1, 4'h2, 4'h3};
    fb = '{4'h0, 4'h9, 4'h2, 4'h7};
    for (int e = 32; e < 64; e++) begin
      step();
      s = (e / 4) % 4;
      c = e % 4;
      want = {2'(s), exp_an(s, c, 1'b1), exp_seg(c, 1'b1, (e < 48) ? fa[s] : fb[s]), (c == 0)};
      got  = {sel, an, seg, digit_tick};
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL snapshot_isolation e=%0d: got sel=%0d an=%b seg=%b tick=%b want sel=%0d an=%b seg=%b tick=%b",
                 e, got[13:12], got[11:8], got[7:1], got[0], want[13:12], want[11:8], want[7:1], want[0]);
      end
      if (e == 40) begin
        i1 = 4'h9;
        i3 = 4'h7;
      end
    end
  endtask

  // 0,0,4,0 shows "40"; then all zeros shows a single "0"
  task automatic test_lzb();
    logic [13:0] got, want;
    logic [3:0] fa [4];
    bit la [4];
    bit lb [4];
    bit lit;
    int s, c;
    fa = '{4'h0, 4'h4, 4'h0, 4'h0};
    la = '{1'b1, 1'b1, 1'b0, 1'b0};
    lb = '{1'b1, 1'b0, 1'b0, 1'b0};
    lzb = 1'b1;
    i0 = 4'h0; i1 = 4'h4; i2 = 4'h0; i3 = 4'h0;
    for (int e = 64; e < 96; e++) begin
      step();
      s = (e / 4) % 4;
      c = e % 4;
      lit = (e < 80) ? la[s] : lb[s];
      want = {2'(s), exp_an(s, c, lit), exp_seg(c, lit, (e < 80) ? fa[s] : 4'h0), (c == 0)};
      got  = {sel, an, seg, digit_tick};
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL lzb e=%0d: got sel=%0d an=%b seg=%b tick=%b want sel=%0d an=%b seg=%b tick=%b",
                 e, got[13:12], got[11:8], got[7:1], got[0], want[13:12], want[11:8], want[7:1], want[0]);
      end
      if (e == 64) begin
        i1 = 4'h0;
      end
    end
  endtask

  task automatic test_enable_freeze();
    logic [13:0] got, want;
    logic [3:0] fd [4];
    int s, c;
    fd = '{4'h5, 4'h6, 4'h7, 4'h8};
    lzb = 1'b0;
    i0 = 4'h5; i1 = 4'h6; i2 = 4'h7; i3 = 4'h8;
    for (int e = 96; e < 103; e++) begin
      step();
      s = (e / 4) % 4;
      c = e % 4;
      want = {2'(s), exp_an(s, c, 1'b1), exp_seg(c, 1'b1, fd[s]), (c == 0)};
      got  = {sel, an, seg, digit_tick};
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL freeze_lead e=%0d: got %b want %b", e, got, want);
      end
    end
    // now sel=1, cnt=2
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      want = {2'd1, 4'b1111, 7'b1111111, 1'b0};
      got  = {sel, an, seg, digit_tick};
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL freeze_hold k=%0d: got %b want %b", k, got, want);
      end
    end
    en = 1'b1;
    step();
    want = {2'd1, 4'b1101, 7'b0000010, 1'b0};
    got  = {sel, an, seg, digit_tick};
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL freeze_resume1: got %b want %b", got, want);
    end
    step();
    want = {2'd2, 4'b1111, 7'b1111111, 1'b1};
    got  = {sel, an, seg, digit_tick};
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL freeze_resume2: got %b want %b", got, want);
    end
  endtask

  task automatic test_mid_reset();
    logic [13:0] got, want;
    logic [3:0] fd [4];
    int s, c;
    fd = '{4'h5, 4'h6, 4'h7, 4'h8};
    for (int k = 1; k <= 5; k++) begin
      step();
      s = 2 + k / 4;
      c = k % 4;
      want = {2'(s), exp_an(s, c, 1'b1), exp_seg(c, 1'b1, fd[s]), (c == 0)};
      got  = {sel, an, seg, digit_tick};
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL mid_reset_lead k=%0d: got %b want %b", k, got, want);
      end
    end
    // sel=3 lit with '8'; reset with en still high and fresh nonzero inputs
    rst = 1'b1;
    i0 = 4'h1; i1 = 4'h2; i2 = 4'h3; i3 = 4'h4;
    step();
    want = {2'd0, 4'b1111, 7'b1111111, 1'b0};
    got  = {sel, an, seg, digit_tick};
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL mid_reset_edge: got %b want %b", got, want);
    end
    rst = 1'b0;
    for (int e = 1; e < 16; e++) begin
      step();
      s = e / 4;
      c = e % 4;
      want = {2'(s), exp_an(s, c, 1'b1), exp_seg(c, 1'b1, 4'h0), (c == 0)};
      got  = {sel, an, seg, digit_tick};
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL mid_reset_frame e=%0d: got %b want %b", e, got, want);
      end
    end
  endtask

  task automatic test_hex();
    logic [13:0] got, want;
    logic [3:0] fh [4];
    int s, c;
    fh = '{4'hA, 4'hB, 4'hE, 4'hF};
    i0 = 4'hA; i1 = 4'hB; i2 = 4'hE; i3 = 4'hF;
    for (int e = 16; e < 32; e++) begin
      step();
      s = (e / 4) % 4;
      c = e % 4;
      want = {2'(s), exp_an(s, c, 1'b1), exp_seg(c, 1'b1, fh[s]), (c == 0)};
      got  = {sel, an, seg, digit_tick};
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL hex e=%0d: got %b want %b", e, got, want);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_scan();
    test_snapshot_isolation();
    test_lzb();
    test_enable_freeze();
    test_mid_reset();
    test_hex();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
